// File: rtl/md_pkg.sv
// md_pkg
//   Shared definitions for the multiply/divide unit. The D/E decode uses the
//   same op encodings, so they live here rather than in the sequencer.
//   Contents: md_op_e op encodings, default latencies, result width, counter
//   width, sequencer state type and two small op-classification helpers.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_RES_W       = 64;
  // Must hold max(MULT_CYCLES, DIV_CYCLES).
  localparam int MD_CNT_W       = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the unit for a multi-cycle run.
  function automatic logic md_is_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith
//   Combinational 64-bit result generator for mult/multu/div/divu.
//   Ports:
//     op          in  3   md_op_e encoding from E
//     a, b        in  32  rs / rt operands
//     res_hi      out 32  product high word, or remainder
//     res_lo      out 32  product low word, or quotient
//     div_by_zero out 1   div/divu with b == 0 (results forced to 0)
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic signed [31:0]         a_s;
  logic signed [31:0]         b_s;
  logic signed [31:0]         q_s;
  logic signed [31:0]         r_s;
  logic        [31:0]         b_safe;
  logic        [31:0]         q_u;
  logic        [31:0]         r_u;
  logic signed [MD_RES_W-1:0] prod_s;
  logic        [MD_RES_W-1:0] prod_u;
  logic                       b_zero;
  logic                       s_ovf;

  always_comb begin
    b_zero = (b == 32'd0);
    // A zero divisor is replaced so the dividers never see it; the result is
    // discarded anyway because commit is disabled for that op.
    b_safe = b_zero ? 32'd1 : b;
    a_s    = signed'(a);
    b_s    = signed'(b_safe);
    // -2^31 / -1 overflows; define it as quotient -2^31, remainder 0 (what
    // 32-bit two's-complement wrap gives) instead of leaving it to the divider.
    s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    prod_s = signed'({{32{a[31]}}, a}) * signed'({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};

    if (s_ovf) begin
      q_s = signed'(32'h8000_0000);
      r_s = '0;
    end else begin
      q_s = a_s / b_s;   // truncates toward zero
      r_s = a_s % b_s;   // sign follows the dividend
    end
    q_u = a / b_safe;
    r_u = a % b_safe;

    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        res_hi = r_s;
        res_lo = q_s;
      end
      MD_DIVU: begin
        res_hi = r_u;
        res_lo = q_u;
      end
      default: ;
    endcase
    if (b_zero) begin
      if (md_is_div(op)) begin
        res_hi = '0;
        res_lo = '0;
      end
    end

    div_by_zero = md_is_div(op) && b_zero;
  end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer
//   E-stage multiply/divide sequencer. Owns HI/LO, launches mult/div ops,
//   models their fixed latency with a down-counter and stalls HI/LO users in D
//   while an op is starting or in flight.
//   Parameters: MULT_CYCLES, DIV_CYCLES (busy cycles per op class, 1..15).
//   Ports:
//     clk      in  1   rising-edge clock
//     reset    in  1   synchronous, active-low
//     E_MD_Op  in  3   md_op_e from E decode
//     E_A/E_B  in  32  forwarded rs/rt
//     D_isMD   in  1   D instruction touches HI/LO or the unit
//     HI/LO    out 32  architectural HI/LO
//     busy     out 1   op in flight
//     start    out 1   op launching this cycle (combinational)
//     stall_D  out 1   hold D (combinational)
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_MD_Op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_isMD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        start,
  output logic        stall_D
);

  localparam logic [MD_CNT_W-1:0] MULT_CNT = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_CNT  = MD_CNT_W'(DIV_CYCLES);

  md_state_e           state;
  md_state_e           state_nxt;
  logic [MD_CNT_W-1:0] cnt;
  logic [31:0]         pend_hi;
  logic [31:0]         pend_lo;
  logic                commit_en;
  logic [31:0]         res_hi;
  logic [31:0]         res_lo;
  logic                div_by_zero;
  logic                last;

  md_arith u_arith (
    .op          (E_MD_Op),
    .a           (E_A),
    .b           (E_B),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  assign last = (cnt == MD_CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: start/stall are combinational so D is held in the launch cycle.
  always_comb begin
    busy    = (state == ST_RUN);
    start   = md_is_start(E_MD_Op) && !busy;
    stall_D = D_isMD && (busy || start);
  end

  // Latency counter: loaded with the op's cycle count, run ends at 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= md_is_div(E_MD_Op) ? DIV_CNT : MULT_CNT;
    end else if (busy) begin
      cnt <= cnt - MD_CNT_W'(1);
    end
  end

  // Launch boundary: capture the result and whether it may be committed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_hi   <= '0;
      pend_lo   <= '0;
      commit_en <= 1'b0;
    end else if (start) begin
      pend_hi   <= res_hi;
      pend_lo   <= res_lo;
      commit_en <= !div_by_zero;
    end
  end

  // Completion boundary: commit pending result, or accept mthi/mtlo when idle.
  // Ops arriving while busy are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (busy) begin
      if (last && commit_en) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else begin
      if (E_MD_Op == MD_MTHI) HI <= E_A;
      if (E_MD_Op == MD_MTLO) LO <= E_A;
    end
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. It owns the HI/LO registers, starts mult/multu/div/divu operations issued from E, and models their fixed multi-cycle latency with a busy counter. While the unit is busy or starting, it stalls any HI/LO-touching instruction waiting in D. It sits beside the ALU and is configured by the E-stage decode fields.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low (reset==0 at a rising edge resets)
- E_MD_Op  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- E_A  in  32  forwarded rs value in E
- E_B  in  32  forwarded rt value in E
- D_isMD  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- HI  out  32  HI register (mfhi source)
- LO  out  32  LO register (mflo source)
- busy  out  1  operation in flight
- start  out  1  combinational; E_MD_Op∈{1..4} and !busy
- stall_D  out  1  combinational; D_isMD & (busy | start)

## Operation
- States: IDLE (busy=0), RUN (busy=1). Counter cnt (4 bits, wide enough for max(MULT_CYCLES, DIV_CYCLES)).
- IDLE→RUN on start. Load cnt with MULT_CYCLES or DIV_CYCLES. Latch the 64-bit pending result {pHI,pLO} computed from E_A/E_B in that cycle.
- mult: {pHI,pLO} = $signed(A)*$signed(B). multu: unsigned 64-bit product.
- div: pLO = signed quotient, truncated toward zero. pHI = remainder, with the sign of the dividend. divu: unsigned quotient/remainder.
- Divide by zero (B==0): busy still runs the full DIV_CYCLES. HI/LO are not written at completion. A commit-enable flag is latched at start.
- RUN: cnt decrements each cycle. When cnt==1: commit {HI,LO}={pHI,pLO} (unless divide by zero), then go to IDLE.
- mthi/mtlo: when !busy, HI (LO) ← E_A at the clock edge. They do not assert busy.
- An op in E while busy is ignored and no state changes. This cannot occur legally because stall_D prevents it; the bench asserts on it.
- Reset values: HI=0, LO=0, busy=0, cnt=0, pending=0, state IDLE. start and stall_D follow from their inputs.

## Timing
- Start in cycle T (op in E, edge at end of T): busy=1 during T+1 … T+N, where N is the op's cycle count.
- HI/LO hold new values from cycle T+N+1, when busy=0.
- stall_D is high in cycle T (start) and in T+1 … T+N. A D-stage mfhi stalled behind the op enters E at T+N+1 and sees the new HI.
- mthi/mtlo issued in cycle T: HI/LO are visible in T+1.
- Back-to-back: a new start is possible in T+N+1.
- Reset mid-RUN: at the reset edge the in-flight result is discarded, busy=0, and HI/LO=0 the next cycle.
- Reset and start in the same cycle: reset wins.

## Structure
- Shared package md_pkg: op encodings (MD_NONE…MD_MTLO), default MULT_CYCLES/DIV_CYCLES, and the 64-bit result width constant. The D/E decode shares these encodings.
- One sub-module: md_arith, a combinational 64-bit mult/div result generator with signed/unsigned select and a div_by_zero flag. The FSM, counter and HI/LO registers live in md_sequencer.

## Test plan
- mult A=0xFFFFFFFE (−2), B=3 at T → busy high T+1…T+5. From T+6, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- divu A=7, B=2, with mflo in D during T → stall_D high T…T+10. From T+11, LO=3, HI=1, and mflo proceeds.
- div A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div with B=0 → busy runs 10 cycles, HI/LO unchanged.
- mthi A=0x12345678 with busy=0 → HI=0x12345678 next cycle, busy stays 0, stall_D=0 for an unrelated D instruction.
- reset=0 at T+3 of a mult → busy=0, HI=LO=0 at T+4, no late commit in T+5/T+6.
- multu 0xFFFFFFFF×0xFFFFFFFF, then a second multu in T+6 → first result HI=0xFFFFFFFE, LO=0x00000001 appears at T+6, the second starts without an idle gap.
